// File: rtl/sort_pkg.sv
// Shared constants, state encoding and sizing helper for the sort chain frame sequencer.
package sort_pkg;

  localparam int unsigned WORD_W = 32;
  localparam logic [WORD_W-1:0] FLUSH_WORD_DEF = 32'h7FFF_FFFF;

  // Frame sequencer states, kept as plain constants for legacy tools.
  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_CLEAR = 3'd1;
  localparam state_t ST_LOAD  = 3'd2;
  localparam state_t ST_FLUSH = 3'd3;
  localparam state_t ST_DRAIN = 3'd4;
  localparam state_t ST_DONE  = 3'd5;

  // Counters must reach 2N inclusive.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(2 * n + 1);
  endfunction

endpackage

// File: rtl/sort_chain_ctrl_if.sv
// FIFO-side signal bundle between the frame sequencer and its source, chain and result FIFOs.
interface sort_chain_ctrl_if;
  import sort_pkg::*;

  logic [WORD_W-1:0] src_dout;
  logic              src_empty_n;
  logic              src_read;
  logic [WORD_W-1:0] chn_din;
  logic              chn_full_n;
  logic              chn_write;
  logic [WORD_W-1:0] chn_dout;
  logic              chn_empty_n;
  logic              chn_read;
  logic [WORD_W-1:0] res_din;
  logic              res_full_n;
  logic              res_write;
  logic              res_last;

  modport master (
    input  src_dout, src_empty_n, chn_full_n, chn_dout, chn_empty_n, res_full_n,
    output src_read, chn_din, chn_write, chn_read, res_din, res_write, res_last
  );

  modport slave (
    output src_dout, src_empty_n, chn_full_n, chn_dout, chn_empty_n, res_full_n,
    input  src_read, chn_din, chn_write, chn_read, res_din, res_write, res_last
  );

endinterface

// File: rtl/sort_out_tracker.sv
// Chain output side: counts 2N reads per frame, discards the first N and forwards the rest.
module sort_out_tracker
  import sort_pkg::*;
#(
  parameter int unsigned N  = 8,
  parameter int unsigned CW = cnt_width(N)
) (
  input  logic ap_clk,
  input  logic ap_rst_n,
  input  logic clear,
  input  logic active,
  input  logic chn_empty_n,
  input  logic res_full_n,
  output logic chn_read,
  output logic res_write,
  output logic res_last,
  output logic drained
);

  localparam logic [CW-1:0] FWD_START = CW'(N);
  localparam logic [CW-1:0] CNT_LAST  = CW'(2 * N - 1);
  localparam logic [CW-1:0] CNT_END   = CW'(2 * N);

  logic [CW-1:0] out_cnt_q, out_cnt_d;

  always_comb begin
    drained   = (out_cnt_q == CNT_END);
    chn_read  = 1'b0;
    res_write = 1'b0;
    if (active && !drained) begin
      // Held values only emerge after N words; earlier outputs are stale and dropped.
      if (out_cnt_q >= FWD_START) begin
        chn_read  = chn_empty_n & res_full_n;
        res_write = chn_empty_n & res_full_n;
      end else begin
        chn_read  = chn_empty_n;
      end
    end
    res_last  = res_write & (out_cnt_q == CNT_LAST);
    out_cnt_d = out_cnt_q;
    if (clear) begin
      out_cnt_d = '0;
    end else if (chn_read) begin
      out_cnt_d = out_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_cnt_q <= '0;
    end else begin
      out_cnt_q <= out_cnt_d;
    end
  end

endmodule

// File: rtl/sort_chain_ctrl.sv
// Frame sequencer for a chain of N insertion-sort cells: clear, load, flush, drain, done.
module sort_chain_ctrl
  import sort_pkg::*;
#(
  parameter int unsigned       N          = 8,
  parameter logic [WORD_W-1:0] FLUSH_WORD = FLUSH_WORD_DEF,
  parameter int unsigned       CLR_CYC    = 2
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              ap_start,
  input  logic              ap_continue,
  output logic              ap_done,
  output logic              ap_idle,
  output logic              ap_ready,
  sort_chain_ctrl_if.master fifo,
  output logic              chain_rst,
  output logic [15:0]       frame_cnt
);

  localparam int unsigned   CW       = cnt_width(N);
  localparam int unsigned   CLW      = (CLR_CYC > 1) ? $clog2(CLR_CYC) : 1;
  localparam logic [CW-1:0] LAST_IN  = CW'(N - 1);
  localparam logic [CLW-1:0] LAST_CLR = CLW'(CLR_CYC - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     in_cnt_q, in_cnt_d;
  logic [CLW-1:0]    clr_cnt_q, clr_cnt_d;
  logic [15:0]       frame_cnt_q, frame_cnt_d;
  logic              src_read, chn_write, out_clear, out_active;
  logic [WORD_W-1:0] chn_din;
  logic              chn_read, res_write, res_last, drained;

  always_comb begin
    state_d     = state_q;
    in_cnt_d    = in_cnt_q;
    clr_cnt_d   = clr_cnt_q;
    frame_cnt_d = frame_cnt_q;
    src_read    = 1'b0;
    chn_write   = 1'b0;
    chn_din     = '0;
    ap_ready    = 1'b0;
    out_clear   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ap_start) begin
          state_d   = ST_CLEAR;
          in_cnt_d  = '0;
          clr_cnt_d = '0;
          out_clear = 1'b1;
        end
      end
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_CLR) begin
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        src_read  = fifo.src_empty_n & fifo.chn_full_n;
        chn_write = src_read;
        chn_din   = fifo.src_dout;
        if (src_read) begin
          if (in_cnt_q == LAST_IN) begin
            ap_ready = 1'b1;
            in_cnt_d = '0;
            state_d  = ST_FLUSH;
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        chn_write = fifo.chn_full_n;
        chn_din   = FLUSH_WORD;
        if (chn_write) begin
          if (in_cnt_q == LAST_IN) begin
            in_cnt_d = '0;
            state_d  = ST_DRAIN;
          end else begin
            in_cnt_d = in_cnt_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        // Leave on the final read itself so ap_done follows it by one cycle.
        if (drained || res_last) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ap_continue) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= ST_IDLE;
      in_cnt_q    <= '0;
      clr_cnt_q   <= '0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      in_cnt_q    <= in_cnt_d;
      clr_cnt_q   <= clr_cnt_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign out_active = (state_q == ST_LOAD) || (state_q == ST_FLUSH) || (state_q == ST_DRAIN);

  sort_out_tracker #(
    .N  (N),
    .CW (CW)
  ) u_out_tracker (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .clear       (out_clear),
    .active      (out_active),
    .chn_empty_n (fifo.chn_empty_n),
    .res_full_n  (fifo.res_full_n),
    .chn_read    (chn_read),
    .res_write   (res_write),
    .res_last    (res_last),
    .drained     (drained)
  );

  assign fifo.src_read  = src_read;
  assign fifo.chn_write = chn_write;
  assign fifo.chn_din   = chn_din;
  assign fifo.chn_read  = chn_read;
  assign fifo.res_write = res_write;
  assign fifo.res_last  = res_last;
  assign fifo.res_din   = res_write ? fifo.chn_dout : '0;

  // The chain is held in reset whenever the sequencer itself is.
  assign chain_rst = (state_q == ST_CLEAR) | ~ap_rst_n;
  assign ap_done   = (state_q == ST_DONE);
  assign ap_idle   = (state_q == ST_IDLE);
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_sort_chain_ctrl.sv
// Randomized frame bench for sort_chain_ctrl against a queue-based chain and FIFO model.
`timescale 1ns/1ps
module tb_sort_chain_ctrl;
  import sort_pkg::*;

  localparam int unsigned N       = 4;
  localparam int unsigned CLR_CYC = 2;
  localparam logic [31:0] FLUSH   = 32'h7FFF_FFFF;
  localparam int          DONE_LAT = 1 + CLR_CYC + 2 * N + 1;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b1;
  logic        ap_start = 1'b0;
  logic        ap_continue = 1'b0;
  logic        ap_done, ap_idle, ap_ready, chain_rst;
  logic [15:0] frame_cnt;

  sort_chain_ctrl_if f ();

  sort_chain_ctrl #(
    .N          (N),
    .FLUSH_WORD (FLUSH),
    .CLR_CYC    (CLR_CYC)
  ) dut (
    .ap_clk      (ap_clk),
    .ap_rst_n    (ap_rst_n),
    .ap_start    (ap_start),
    .ap_continue (ap_continue),
    .ap_done     (ap_done),
    .ap_idle     (ap_idle),
    .ap_ready    (ap_ready),
    .fifo        (f),
    .chain_rst   (chain_rst),
    .frame_cnt   (frame_cnt)
  );

  always #5 ap_clk = ~ap_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp_v);
    end
  endtask

  logic [31:0] frame_words[$];
  logic [31:0] sorted_q[$];
  logic [31:0] src_q[$];
  logic [31:0] chain_q[$];
  logic [31:0] exp_in[$];
  logic [31:0] exp_res[$];
  logic [15:0] fc_model = 16'd0;
  int wr_idx, rd_idx, res_idx, ready_cnt, clr_seen, first_wr, done_at;
  int cyc = 0;
  int start_cyc = 0;
  int src_p = 100, chn_p = 100, res_p = 100, vld_p = 100;
  int stall_from = -1, stall_len = 0;
  bit src_gap = 1'b0, start_req = 1'b0, cont_req = 1'b0, quiet = 1'b0, s_done = 1'b0;

  // One clock: drive FIFO/chain model at negedge, sample DUT strobes 1ns later.
  task automatic cycle();
    int rel;
    bit stall;
    @(negedge ap_clk);
    rel   = cyc - start_cyc;
    stall = (stall_from >= 0) && (rel >= stall_from) && (rel < stall_from + stall_len);
    ap_start      = start_req;
    ap_continue   = cont_req;
    f.src_empty_n = (src_q.size() > 0) && !(src_gap && (cyc % 2 == 1)) &&
                    ($urandom_range(99) < src_p);
    f.src_dout    = (src_q.size() > 0) ? src_q[0] : 32'h0;
    f.chn_full_n  = ($urandom_range(99) < chn_p);
    f.chn_empty_n = (chain_q.size() > 0) && ($urandom_range(99) < vld_p);
    f.chn_dout    = (chain_q.size() > 0) ? chain_q[0] : 32'h0;
    f.res_full_n  = !stall && ($urandom_range(99) < res_p);
    #1;
    if (quiet) check("quiet", 32'({f.src_read, f.chn_write, f.chn_read, f.res_write}), 32'd0);
    if (stall) check("stall_no_read", 32'(f.chn_read), 32'd0);
    if (chain_rst && ap_rst_n) clr_seen++;
    if (f.src_read) begin
      check("src_rd_valid", 32'({f.src_empty_n, f.chn_write}), 32'd3);
      if (src_q.size() > 0) void'(src_q.pop_front());
    end
    if (ap_ready) begin
      ready_cnt++;
      check("ready_on_last_pop", 32'({f.src_read, src_q.size() == 0}), 32'd3);
    end
    if (f.chn_write) begin
      if (first_wr < 0) first_wr = rel;
      check("chn_full_ok", 32'(f.chn_full_n), 32'd1);
      if (exp_in.size() == 0) begin
        check("chn_extra_write", 32'd1, 32'd0);
      end else begin
        check("chn_din", f.chn_din, exp_in.pop_front());
        chain_q.push_back((wr_idx < N) ? (32'hBAD0_0000 | 32'(wr_idx)) : sorted_q[wr_idx - N]);
        wr_idx++;
      end
    end
    if (f.chn_read) begin
      check("chn_rd_valid", 32'(f.chn_empty_n), 32'd1);
      check("fwd_phase", 32'(f.res_write), 32'(rd_idx >= N));
      if (chain_q.size() > 0) void'(chain_q.pop_front());
      rd_idx++;
    end
    if (f.res_write) begin
      check("res_hs", 32'({f.res_full_n, f.chn_read}), 32'd3);
      if (exp_res.size() == 0) begin
        check("res_extra_write", 32'd1, 32'd0);
      end else begin
        check("res_din", f.res_din, exp_res.pop_front());
        check("res_last", 32'(f.res_last), 32'(res_idx == N - 1));
      end
      res_idx++;
    end else if (f.res_last) begin
      check("res_last_unqualified", 32'd1, 32'd0);
    end
    if (ap_done && done_at < 0) done_at = rel;
    s_done = ap_done;
    cyc++;
  endtask

  task automatic setup_frame();
    logic [31:0] t;
    sorted_q = frame_words;
    for (int i = 0; i < N; i++) begin
      for (int j = i + 1; j < N; j++) begin
        if ($signed(sorted_q[j]) > $signed(sorted_q[i])) begin
          t           = sorted_q[i];
          sorted_q[i] = sorted_q[j];
          sorted_q[j] = t;
        end
      end
    end
    src_q   = frame_words;
    exp_in  = frame_words;
    for (int i = 0; i < N; i++) exp_in.push_back(FLUSH);
    exp_res = sorted_q;
    chain_q.delete();
    wr_idx = 0; rd_idx = 0; res_idx = 0; ready_cnt = 0; clr_seen = 0;
    first_wr = -1; done_at = -1; s_done = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic run_frame(input int cont_hold, input bit ideal);
    setup_frame();
    start_req = 1'b1;
    cont_req  = (cont_hold == 0);
    cycle();
    start_req = 1'b0;
    for (int i = 0; i < 400 && !s_done; i++) cycle();
    if (!s_done) begin
      check("done_timeout", 32'd0, 32'd1);
      cont_req = 1'b0;
      return;
    end
    if (cont_hold > 0) begin
      for (int i = 1; i < cont_hold; i++) begin
        cycle();
        check("done_held", 32'(ap_done), 32'd1);
        check("frame_cnt_hold", 32'(frame_cnt), 32'(fc_model));
      end
      cont_req = 1'b1;
      cycle();
      check("done_at_continue", 32'(ap_done), 32'd1);
    end
    cont_req = 1'b0;
    fc_model = fc_model + 16'd1;
    cycle();
    check("idle_after_done", 32'({ap_idle, ap_done}), 32'd2);
    check("frame_cnt", 32'(frame_cnt), 32'(fc_model));
    check("res_count", 32'(res_idx), 32'(N));
    check("ready_count", 32'(ready_cnt), 32'd1);
    check("clear_cycles", 32'(clr_seen), 32'(CLR_CYC));
    if (ideal) begin
      check("first_write_lat", 32'(first_wr), 32'(1 + CLR_CYC));
      check("done_lat", 32'(done_at), 32'(DONE_LAT));
    end
  endtask

  task automatic check_reset_outputs();
    check("rst_chain_rst", 32'(chain_rst), 32'd1);
    check("rst_idle", 32'({ap_idle, ap_done, ap_ready}), 32'd4);
    check("rst_strobes", 32'({f.src_read, f.chn_write, f.chn_read, f.res_write, f.res_last}),
          32'd0);
    check("rst_data", f.chn_din | f.res_din, 32'd0);
    check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
  endtask

  task automatic rand_words();
    frame_words.delete();
    for (int i = 0; i < N; i++) begin
      if ($urandom_range(1) == 0) frame_words.push_back(32'($urandom_range(20)) - 32'd10);
      else frame_words.push_back($urandom());
    end
  endtask

  initial begin
    f.src_empty_n = 1'b0; f.src_dout = '0; f.chn_full_n = 1'b0;
    f.chn_empty_n = 1'b0; f.chn_dout = '0; f.res_full_n = 1'b0;

    // Reset then idle.
    #1 ap_rst_n = 1'b0;
    #2 check_reset_outputs();
    #20 ap_rst_n = 1'b1;
    quiet = 1'b1;
    repeat (4) begin
      cycle();
      check("idle_post_rst", 32'({ap_idle, chain_rst}), 32'd2);
    end
    quiet = 1'b0;

    // Ideal flow, fixed frame.
    frame_words = {32'd5, 32'hFFFF_FFFD, 32'd9, 32'd0};
    run_frame(1, 1'b1);

    // Source gaps every other cycle.
    src_gap = 1'b1;
    run_frame(1, 1'b0);
    src_gap = 1'b0;

    // Result FIFO full for 10 cycles during DRAIN.
    rand_words();
    stall_from = DONE_LAT - 1;
    stall_len  = 10;
    run_frame(1, 1'b0);
    stall_from = -1;

    // Reset mid-FLUSH.
    rand_words();
    setup_frame();
    start_req = 1'b1;
    cycle();
    start_req = 1'b0;
    while (cyc - start_cyc < 1 + CLR_CYC + N + 1) cycle();
    @(negedge ap_clk);
    #2 ap_rst_n = 1'b0;
    #1 check_reset_outputs();
    fc_model = 16'd0;
    @(posedge ap_clk);
    #2 ap_rst_n = 1'b1;
    src_q.delete(); exp_in.delete(); exp_res.delete();
    quiet = 1'b1;
    repeat (6) cycle();
    quiet = 1'b0;

    // Back-to-back frames with a long and a zero continue hold.
    rand_words();
    run_frame(5, 1'b1);
    rand_words();
    run_frame(0, 1'b1);
    check("frame_cnt_two", 32'(frame_cnt), 32'd2);

    // Randomized backpressure on every FIFO.
    for (int k = 0; k < 6; k++) begin
      rand_words();
      src_p = $urandom_range(100, 40);
      chn_p = $urandom_range(100, 40);
      res_p = $urandom_range(100, 40);
      vld_p = $urandom_range(100, 40);
      run_frame(int'($urandom_range(3)), 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1);
  end

endmodule
